// File: rtl/rics_pkg.sv
// Shared constants and types for the RICS datapath register file.
package rics_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned ADDR_WIDTH = 3;
    localparam int unsigned NUM_REGS   = 2 ** ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [ADDR_WIDTH-1:0] reg_idx_t;

endpackage

// File: rtl/register_file_read_port.sv
// One combinational read port: address mux, R0 zero forcing and, when REGFILE_BYPASS_EN
// is defined, write-to-read forwarding of the in-flight write data.
module register_file_read_port #(
    parameter int unsigned DATA_WIDTH = rics_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = rics_pkg::ADDR_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] regs_i [2**ADDR_WIDTH],
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic [DATA_WIDTH-1:0] data_o
);
    import rics_pkg::*;

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        data_o = regs_i[addr_i];
        if (wr_en_i && (wr_addr_i == addr_i)) begin
            data_o = wr_data_i;
        end
        if (addr_i == '0) begin
            data_o = '0;
        end
    end
`else
    logic unused_bypass;
    assign unused_bypass = ^{wr_en_i, wr_addr_i, wr_data_i};

    always_comb begin
        data_o = regs_i[addr_i];
        if (addr_i == '0) begin
            data_o = '0;
        end
    end
`endif

endmodule

// File: rtl/register_file.sv
// Eight-entry register file, one synchronous write port, two combinational read ports.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module register_file #(
    parameter int unsigned DATA_WIDTH = rics_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = rics_pkg::ADDR_WIDTH
) (
    input  logic                  inp_clk,
    input  logic                  inp_rst,
    input  logic                  inp_flagWrite,
    input  logic [DATA_WIDTH-1:0] inp_dataWrite,
    input  logic [ADDR_WIDTH-1:0] inp_regWrite,
    input  logic [ADDR_WIDTH-1:0] inp_rs,
    input  logic [ADDR_WIDTH-1:0] inp_rd,
    output logic [DATA_WIDTH-1:0] out_readdata1,
    output logic [DATA_WIDTH-1:0] out_readData2
);
    import rics_pkg::*;

    localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NumRegs];
    logic [DATA_WIDTH-1:0] regs_d [NumRegs];
    logic                  wr_en;
    logic                  byp_en;

    assign wr_en  = inp_flagWrite && (inp_regWrite != '0);
    // Forwarding must not expose data that reset is about to discard.
    assign byp_en = wr_en && !inp_rst;

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[inp_regWrite] = inp_dataWrite;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge inp_clk) begin
        if (inp_rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    register_file_read_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_read_port_1 (
        .regs_i   (regs_q),
        .addr_i   (inp_rs),
        .wr_en_i  (byp_en),
        .wr_addr_i(inp_regWrite),
        .wr_data_i(inp_dataWrite),
        .data_o   (out_readdata1)
    );

    register_file_read_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_read_port_2 (
        .regs_i   (regs_q),
        .addr_i   (inp_rd),
        .wr_en_i  (byp_en),
        .wr_addr_i(inp_regWrite),
        .wr_data_i(inp_dataWrite),
        .data_o   (out_readData2)
    );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus random traffic against
// an array-based reference model. Build with REGFILE_BYPASS_EN to check forwarding.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic        we;
    logic [15:0] wd;
    logic [2:0]  wa;
    logic [2:0]  rs;
    logic [2:0]  rd;
    logic [15:0] rd1;
    logic [15:0] rd2;

    logic [15:0] model [8];
    bit          model_valid;
    int          checks;
    int          errors;

    register_file u_dut (
        .inp_clk      (clk),
        .inp_rst      (rst),
        .inp_flagWrite(we),
        .inp_dataWrite(wd),
        .inp_regWrite (wa),
        .inp_rs       (rs),
        .inp_rd       (rd),
        .out_readdata1(rd1),
        .out_readData2(rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Value a read port should show right now, given the inputs currently applied.
    function automatic logic [15:0] exp_read(input logic [2:0] addr);
        if (addr == 3'd0) return 16'h0000;
`ifdef REGFILE_BYPASS_EN
        if (we && !rst && wa != 3'd0 && addr == wa) return wd;
`endif
        return model[addr];
    endfunction

    // Apply inputs, check reads before the edge, clock, update model, check after the edge.
    task automatic do_cycle(input string tag, input bit r, input bit w, input logic [2:0] a,
                            input logic [15:0] d, input logic [2:0] s1, input logic [2:0] s2);
        rst = r; we = w; wa = a; wd = d; rs = s1; rd = s2;
        #1;
        if (model_valid) begin
            check_eq({tag, "_pre1"}, rd1, exp_read(s1));
            check_eq({tag, "_pre2"}, rd2, exp_read(s2));
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 8; i++) model[i] = 16'h0000;
            model_valid = 1'b1;
        end else if (w && a != 3'd0) begin
            model[a] = d;
        end
        #1;
        if (model_valid) begin
            check_eq({tag, "_post1"}, rd1, exp_read(s1));
            check_eq({tag, "_post2"}, rd2, exp_read(s2));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_valid = 1'b0;
        rst = 1'b0; we = 1'b0; wa = '0; wd = '0; rs = '0; rd = '0;

        // Random writes before any reset, then reset held for two edges.
        for (int i = 0; i < 4; i++) begin
            do_cycle("prewr", 1'b0, 1'b1, 3'($urandom_range(1, 7)), 16'($urandom), 3'd1, 3'd2);
        end
        do_cycle("rst_a", 1'b1, 1'b1, 3'd3, 16'h1234, 3'd3, 3'd0);
        do_cycle("rst_b", 1'b1, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd2);
        for (int k = 0; k < 8; k++) begin
            do_cycle("sweep", 1'b0, 1'b0, 3'd0, 16'h0000, 3'(k), 3'(7 - k));
            check_eq("sweep_rs_zero", rd1, 16'h0000);
            check_eq("sweep_rd_zero", rd2, 16'h0000);
        end

        // Write 0x1111*k to Rk and read back.
        for (int k = 1; k < 8; k++) begin
            do_cycle("wr_k", 1'b0, 1'b1, 3'(k), 16'(16'h1111 * k), 3'(k), 3'd0);
        end
        do_cycle("rb37", 1'b0, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd7);
        check_eq("rb_r3", rd1, 16'h3333);
        check_eq("rb_r7", rd2, 16'h7777);
        do_cycle("rb55", 1'b0, 1'b0, 3'd0, 16'h0000, 3'd5, 3'd5);
        check_eq("rb_r5_p1", rd1, 16'h5555);
        check_eq("rb_r5_p2", rd2, 16'h5555);

        // R0 protection.
        do_cycle("r0wr", 1'b0, 1'b1, 3'd0, 16'hBEEF, 3'd0, 3'd0);
        check_eq("r0_reads_zero", rd1, 16'h0000);

        // Write-enable gating.
        do_cycle("gate", 1'b0, 1'b0, 3'd2, 16'hDEAD, 3'd2, 3'd2);
        check_eq("gate_r2_held", rd1, 16'h2222);

        // Same-cycle collision on R4.
        rst = 1'b0; we = 1'b1; wa = 3'd4; wd = 16'hA5A5; rs = 3'd4; rd = 3'd1;
        #1;
`ifdef REGFILE_BYPASS_EN
        check_eq("coll_pre", rd1, 16'hA5A5);
`else
        check_eq("coll_pre", rd1, 16'h4444);
`endif
        do_cycle("coll", 1'b0, 1'b1, 3'd4, 16'hA5A5, 3'd4, 3'd1);
        check_eq("coll_post", rd1, 16'hA5A5);

        // Reset beats a simultaneous write.
        do_cycle("rstwr", 1'b1, 1'b1, 3'd6, 16'hFFFF, 3'd6, 3'd4);
        check_eq("rstwr_r6", rd1, 16'h0000);
        check_eq("rstwr_r4", rd2, 16'h0000);

        // Random traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            do_cycle("rand", ($urandom_range(0, 31) == 0), bit'($urandom_range(0, 1)),
                     3'($urandom), 16'($urandom), 3'($urandom), 3'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
